// File: rtl/modulation_segment_tx.sv
// Segment modulator: serialises a data word LSB first, emitting SEG_LEN
// Q16.16 samples per bit (alternating +AMP/-AMP for a 1, inverted for a 0)
// under a valid/ready handshake, then pulses valid once on completion.
// Optional build macro MOD_DIFF_EN: differential symbol encoding
// (d_n = b_n ^ d_(n-1), d_(-1) = 0 at each accepted start).
module modulation_segment_tx #(
  parameter int unsigned SEG_LEN  = 10,
  parameter int unsigned NUM_BITS = 32,
  parameter logic [31:0] AMP      = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] input_bit,
  input  logic        sample_ready,
  output logic [31:0] sample_out,
  output logic        sample_valid,
  output logic [5:0]  bit_idx,
  output logic [7:0]  samp_idx,
  output logic        last,
  output logic        valid,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 6;
  localparam int unsigned SW = 8;

  localparam logic [SW-1:0] SAMP_LAST = SW'(SEG_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_BITS - 1);
  localparam logic [DW-1:0] AMP_POS   = AMP;
  localparam logic [DW-1:0] AMP_NEG   = DW'(32'd0 - AMP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DW-1:0] shreg, shreg_n;
  logic [BW-1:0] bit_n;
  logic [SW-1:0] samp_n;
  logic [DW-1:0] sample_n;
  logic          sample_valid_n;
  logic          last_n;
  logic          valid_n;
  logic          busy_n;
  logic          sym_c;
  logic          xfer_c;
  logic          seg_end_c;

`ifdef MOD_DIFF_EN
  logic          prev_q, prev_n;
`endif

  assign xfer_c    = sample_valid & sample_ready;
  assign seg_end_c = (samp_idx == SAMP_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SEND;
      SEND:    if (xfer_c && last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs
  always_comb begin
    shreg_n = shreg;
    bit_n   = bit_idx;
    samp_n  = samp_idx;
`ifdef MOD_DIFF_EN
    prev_n  = prev_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          shreg_n = input_bit;
          bit_n   = '0;
          samp_n  = '0;
`ifdef MOD_DIFF_EN
          prev_n  = 1'b0;
`endif
        end
      end
      SEND: begin
        if (xfer_c) begin
          if (last) begin
            bit_n  = '0;
            samp_n = '0;
          end else if (seg_end_c) begin
            samp_n  = '0;
            bit_n   = bit_idx + BW'(1);
            shreg_n = shreg >> 1;
`ifdef MOD_DIFF_EN
            prev_n  = shreg[0] ^ prev_q;
`endif
          end else begin
            samp_n = samp_idx + SW'(1);
          end
        end
      end
      default: ;
    endcase

`ifdef MOD_DIFF_EN
    sym_c = shreg_n[0] ^ prev_n;
`else
    sym_c = shreg_n[0];
`endif

    sample_valid_n = (state_n == SEND);
    sample_n       = '0;
    if (sample_valid_n) sample_n = (sym_c ^ samp_n[0]) ? AMP_POS : AMP_NEG;
    last_n  = sample_valid_n && (bit_n == BIT_LAST) && (samp_n == SAMP_LAST);
    valid_n = (state_n == DONE);
    busy_n  = (state_n != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg        <= '0;
      bit_idx      <= '0;
      samp_idx     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      last         <= 1'b0;
      valid        <= 1'b0;
      busy         <= 1'b0;
`ifdef MOD_DIFF_EN
      prev_q       <= 1'b0;
`endif
    end else begin
      shreg        <= shreg_n;
      bit_idx      <= bit_n;
      samp_idx     <= samp_n;
      sample_out   <= sample_n;
      sample_valid <= sample_valid_n;
      last         <= last_n;
      valid        <= valid_n;
      busy         <= busy_n;
`ifdef MOD_DIFF_EN
      prev_q       <= prev_n;
`endif
    end
  end

endmodule

// File: doc/modulation_segment_tx.md
Name: modulation_segment_tx

Overview:
Segment modulator, the transmit counterpart of the demodulation segment blocks. It accepts a 32-bit data word on a start pulse and serialises it LSB first. Each bit becomes SEG_LEN Q16.16 samples: the alternating reference pattern ref for bit 1, or the inverted pattern ref_m for bit 0. Samples stream out under a valid/ready handshake; the block then reports completion with the same start/valid/busy convention as the demodulator.

Parameters:
SEG_LEN, 10, samples per bit (2..255)
NUM_BITS, 32, bits serialised per start (1..32)
AMP, 32'h0001_0000, reference amplitude in Q16.16 (+1.0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin transfer of input_bit; honoured only in IDLE
input_bit  input  32  data word; bit 0 is sent first
sample_ready  input  1  downstream accepts sample this cycle
sample_out  output  32  Q16.16 two's-complement sample
sample_valid  output  1  sample_out holds a valid sample
bit_idx  output  6  index of the bit currently being sent
samp_idx  output  8  sample index within the current segment
last  output  1  current sample is the final sample of the word
valid  output  1  one-cycle pulse after the final sample is accepted
busy  output  1  transfer in progress

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; sample_out=0, sample_valid=0, bit_idx=0, samp_idx=0, last=0, valid=0, busy=0; shift register cleared.
- States: IDLE, SEND, DONE.
- IDLE -> SEND: on start=1, latch input_bit into the shift register and clear both counters. busy=1 and sample_valid=1 from the next cycle, so first-sample latency is 1 cycle.
- SEND:
  - Transfer occurs when sample_valid && sample_ready.
  - With sample_ready low, all outputs hold stable with no limit.
  - On each transfer, samp_idx increments.
  - When samp_idx==SEG_LEN-1: samp_idx wraps to 0, bit_idx increments and the shift register shifts right by one.
- Sample value, k = samp_idx, d = symbol bit:
  - d=1: k even -> +AMP, k odd -> -AMP (AMP=65536 gives 0x0001_0000 / 0xFFFF_0000).
  - d=0: the negation of the above.
  - Negation is 32-bit two's complement, no saturation.
- last=1 when bit_idx==NUM_BITS-1 and samp_idx==SEG_LEN-1.
- SEND -> DONE: on the transfer where last=1. In DONE: sample_valid=0, sample_out=0, valid=1 for exactly one cycle, busy=1. DONE -> IDLE unconditionally on the next cycle, where busy=0.
- sample_out=0 whenever sample_valid=0.
- start in SEND or DONE is ignored and does not re-latch input_bit. A start arriving in IDLE on the cycle after DONE is accepted.
- Transfer time with sample_ready held high: NUM_BITS*SEG_LEN cycles. With defaults, start at cycle t gives first sample at t+1, last sample at t+320, valid at t+321.
- Reset mid-transfer aborts immediately to IDLE. No valid pulse is produced and nothing resumes.

Optional Feature:
Macro: MOD_DIFF_EN.
- Defined: differential encoding. Symbol d_n = b_n XOR d_(n-1), with d_(-1)=0 at every accepted start; d_n is computed as bit n enters the segment.
- Undefined: d_n = b_n. No extra register is instantiated.
- Ports and timing are identical in both builds.

Test Plan:
- Reset low mid-SEND, then high, ready=1 -> all outputs 0, state IDLE; the next start restarts cleanly from bit 0, sample 0.
- input_bit=0x0000_0001, start 1 cycle, ready=1 -> samples 0..9 alternate 0x00010000/0xFFFF0000 starting with +, next 310 samples start with 0xFFFF0000; last on sample 320; valid pulse at t+321; busy low at t+322.
- input_bit=0xAAAA_AAAA, ready toggling 1/0 each cycle -> sample_out, samp_idx and bit_idx hold while ready=0; 320 transfers total; valid one cycle after the 320th transfer.
- start re-asserted with input_bit=0xFFFF_FFFF during SEND -> ignored; sample stream still matches the first word.
- MOD_DIFF_EN defined, input_bit=0x0000_0003 -> d0=1, d1=0, d2..d31=0. Segment 0 starts 0x00010000; segments 1..31 start 0xFFFF0000.
- Back-to-back: start asserted in the cycle after the valid pulse, with a new word -> accepted; first sample of the new word appears 1 cycle later.
